// File: rtl/mips25_adder_pkg.sv
// rtl/mips25_adder_pkg.sv - shared constants, delay-line entry type and result function for the MIPS25 prefix adder
package mips25_adder_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_TREE_DEPTH = 3;
    localparam int MAX_WIDTH      = 64;

    // p is sized for the widest adder; narrower instances zero-extend into it
    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] p;
        logic                 cin;
    } dl_entry_t;

    typedef struct packed {
        logic                 zero;
        logic                 ovf;
        logic                 cout;
        logic [MAX_WIDTH-1:0] sum;
    } sum_result_t;

    function automatic sum_result_t calc_result(
        input logic [MAX_WIDTH-1:0] p,
        input logic                 cin,
        input logic [MAX_WIDTH-1:0] gc,
        input int                   width
    );
        sum_result_t          r;
        logic [MAX_WIDTH-1:0] gc_msb;
        logic [MAX_WIDTH-1:0] gc_msb_m1;
        r         = '0;
        r.sum[0]  = p[0] ^ cin;
        for (int i = 1; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                r.sum[i] = p[i] ^ gc[i-1];
            end
        end
        gc_msb    = gc >> (width - 1);
        gc_msb_m1 = gc >> (width - 2);
        r.cout    = gc_msb[0];
        r.ovf     = gc_msb[0] ^ gc_msb_m1[0];
        r.zero    = (r.sum == '0);
        return r;
    endfunction

endpackage

// File: rtl/prefix_delay_line.sv
// rtl/prefix_delay_line.sv - non-stalling valid/data shift register matching p/cin to the prefix-tree depth
module prefix_delay_line
    import mips25_adder_pkg::*;
#(
    parameter int DEPTH = DEF_TREE_DEPTH
) (
    input  logic      clkpos,
    input  logic      rst_n,
    input  dl_entry_t in_entry,
    output dl_entry_t head
);

    dl_entry_t stage [DEPTH];

    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // idle slots keep the previous data so the p bus does not toggle needlessly
            stage[0].valid <= in_entry.valid;
            if (in_entry.valid) begin
                stage[0].p   <= in_entry.p;
                stage[0].cin <= in_entry.cin;
            end
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head = stage[DEPTH-1];

endmodule

// File: rtl/prefix_sum_stage.sv
// rtl/prefix_sum_stage.sv - final sum/flag stage of the MIPS25 phase-pipelined parallel-prefix adder
module prefix_sum_stage
    import mips25_adder_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TREE_DEPTH = DEF_TREE_DEPTH
) (
    input  logic             clkpos,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] p_in,
    input  logic             cin,
    input  logic             gc_valid,
    input  logic [WIDTH-1:0] gc,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             align_err
);

    dl_entry_t   in_entry;
    dl_entry_t   head;
    sum_result_t res;
    logic        take;
    logic        mismatch;
    logic        unused_res;

    assign in_entry = '{valid: in_valid, p: MAX_WIDTH'(p_in), cin: cin};

    prefix_delay_line #(
        .DEPTH (TREE_DEPTH)
    ) u_delay (
        .clkpos   (clkpos),
        .rst_n    (rst_n),
        .in_entry (in_entry),
        .head     (head)
    );

    always_comb begin
        res = calc_result(head.p, head.cin, MAX_WIDTH'(gc), WIDTH);
    end

    assign unused_res = ^res.sum;
    assign take       = gc_valid & head.valid;
    assign mismatch   = gc_valid ^ head.valid;

    // a misaligned head entry is dropped, never retried
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            align_err <= 1'b0;
        end else begin
            out_valid <= take;
            if (take) begin
                sum  <= res.sum[WIDTH-1:0];
                cout <= res.cout;
                ovf  <= res.ovf;
                zero <= res.zero;
            end
            if (mismatch) begin
                align_err <= 1'b1;
            end else if (err_clr) begin
                align_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prefix_sum_stage.sv
// tb/tb_prefix_sum_stage.sv - randomized self-checking bench for prefix_sum_stage against an arithmetic adder model
module tb_prefix_sum_stage;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int NS = 32;

    logic         clkpos = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] p_in;
    logic         cin;
    logic         gc_valid;
    logic [W-1:0] gc;
    logic         err_clr;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         align_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] op_a [NS];
    logic [7:0] op_b [NS];
    logic       op_c [NS];
    logic       op_v [NS];
    int         n_ops;

    always #5 clkpos = ~clkpos;

    prefix_sum_stage #(
        .WIDTH      (W),
        .TREE_DEPTH (D)
    ) dut (
        .clkpos    (clkpos),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .p_in      (p_in),
        .cin       (cin),
        .gc_valid  (gc_valid),
        .gc        (gc),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .align_err (align_err)
    );

    // carry out of bit i, from plain addition of the low i+1 bits
    function automatic logic [7:0] model_gc(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [7:0] g;
        for (int i = 0; i < 8; i++) begin
            int unsigned m;
            int unsigned s;
            m    = (32'd1 << (i + 1)) - 32'd1;
            s    = (32'(a) & m) + (32'(b) & m) + 32'(c);
            g[i] = ((s >> (i + 1)) & 32'd1) != 0;
        end
        return g;
    endfunction

    // {zero, ovf, cout, sum} of a + b + c
    function automatic logic [10:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned t;
        logic [7:0]  s;
        logic        co;
        logic        ov;
        logic        z;
        t  = 32'(a) + 32'(b) + 32'(c);
        s  = t[7:0];
        co = t[8];
        ov = (a[7] == b[7]) && (s[7] != a[7]);
        z  = (s == 8'h00);
        return {z, ov, co, s};
    endfunction

    task automatic tick();
        @(posedge clkpos);
        #1;
    endtask

    task automatic clear_ops();
        n_ops = 0;
        for (int i = 0; i < NS; i++) begin
            op_a[i] = 8'h00;
            op_b[i] = 8'h00;
            op_c[i] = 1'b0;
            op_v[i] = 1'b0;
        end
    endtask

    // upstream emulation: op k enters at slot k, its carries arrive D slots later
    task automatic drive_slot(input int k);
        int j;
        j       = k - D;
        err_clr = 1'b0;
        if (k < n_ops) begin
            in_valid = op_v[k];
            p_in     = op_a[k] ^ op_b[k];
            cin      = op_c[k];
        end else begin
            in_valid = 1'b0;
            p_in     = 8'($urandom);
            cin      = 1'($urandom);
        end
        if (j >= 0 && j < n_ops && op_v[j]) begin
            gc_valid = 1'b1;
            gc       = model_gc(op_a[j], op_b[j], op_c[j]);
        end else begin
            gc_valid = 1'b0;
            gc       = 8'($urandom);
        end
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        gc_valid = 1'b0;
        err_clr  = 1'b0;
        p_in     = 8'($urandom);
        gc       = 8'($urandom);
        cin      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go_idle();
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", zero); end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL reset_align_err got=%b exp=0", align_err); end
        @(negedge clkpos);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] es [3];
        logic       ec [3];
        logic       eo [3];
        logic       ez [3];
        int         j;
        es = '{8'h4B, 8'h80, 8'h00};
        ec = '{1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0};
        ez = '{1'b0, 1'b0, 1'b1};
        clear_ops();
        n_ops = 3;
        op_a[0] = 8'h3C; op_b[0] = 8'h0F; op_c[0] = 1'b0; op_v[0] = 1'b1;
        op_a[1] = 8'h7F; op_b[1] = 8'h01; op_c[1] = 1'b0; op_v[1] = 1'b1;
        op_a[2] = 8'hFF; op_b[2] = 8'h01; op_c[2] = 1'b0; op_v[2] = 1'b1;
        for (int k = 0; k < n_ops + D; k++) begin
            drive_slot(k);
            tick();
            j = k - D;
            total++;
            if (out_valid !== (j >= 0)) begin
                bad++; $display("FAIL directed_out_valid slot=%0d got=%b exp=%b", k, out_valid, (j >= 0));
            end
            if (j >= 0) begin
                total++; if (sum !== es[j]) begin bad++; $display("FAIL directed_sum op=%0d got=%h exp=%h", j, sum, es[j]); end
                total++; if (cout !== ec[j]) begin bad++; $display("FAIL directed_cout op=%0d got=%b exp=%b", j, cout, ec[j]); end
                total++; if (ovf !== eo[j]) begin bad++; $display("FAIL directed_ovf op=%0d got=%b exp=%b", j, ovf, eo[j]); end
                total++; if (zero !== ez[j]) begin bad++; $display("FAIL directed_zero op=%0d got=%b exp=%b", j, zero, ez[j]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         j;
        logic [10:0] exp_r;
        clear_ops();
        n_ops = 4;
        for (int i = 0; i < n_ops; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
            op_c[i] = 1'($urandom);
            op_v[i] = 1'b1;
        end
        for (int k = 0; k < n_ops + D; k++) begin
            drive_slot(k);
            tick();
            j = k - D;
            total++;
            if (out_valid !== (j >= 0)) begin
                bad++; $display("FAIL b2b_out_valid slot=%0d got=%b exp=%b", k, out_valid, (j >= 0));
            end
            if (j >= 0) begin
                exp_r = model_res(op_a[j], op_b[j], op_c[j]);
                total++;
                if ({zero, ovf, cout, sum} !== exp_r) begin
                    bad++; $display("FAIL b2b_result op=%0d got=%h exp=%h", j, {zero, ovf, cout, sum}, exp_r);
                end
            end
        end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL b2b_align_err got=%b exp=0", align_err); end
    endtask

    task automatic test_random_stream();
        int          j;
        logic        exp_v;
        logic [10:0] exp_r;
        clear_ops();
        n_ops = 24;
        for (int i = 0; i < n_ops; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
            op_c[i] = 1'($urandom);
            op_v[i] = ($urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < n_ops + D; k++) begin
            drive_slot(k);
            tick();
            j     = k - D;
            exp_v = (j >= 0) && op_v[j];
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL rand_out_valid slot=%0d got=%b exp=%b", k, out_valid, exp_v);
            end
            if (exp_v) begin
                exp_r = model_res(op_a[j], op_b[j], op_c[j]);
                total++;
                if ({zero, ovf, cout, sum} !== exp_r) begin
                    bad++; $display("FAIL rand_result op=%0d got=%h exp=%h", j, {zero, ovf, cout, sum}, exp_r);
                end
            end
        end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL rand_align_err got=%b exp=0", align_err); end
    endtask

    task automatic test_misalign();
        go_idle();
        in_valid = 1'b1;
        p_in     = 8'($urandom);
        cin      = 1'($urandom);
        tick();
        go_idle();
        tick();
        gc_valid = 1'b1;
        tick();
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL early_gc_align_err got=%b exp=1", align_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_gc_out_valid got=%b exp=0", out_valid); end
        gc_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL orphan_head_out_valid got=%b exp=0", out_valid); end
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL orphan_head_align_err got=%b exp=1", align_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", align_err); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_retry_out_valid got=%b exp=0", out_valid); end
        gc_valid = 1'b1;
        err_clr  = 1'b1;
        tick();
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL set_over_clr got=%b exp=1", align_err); end
        gc_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL err_clr_again got=%b exp=0", align_err); end
    endtask

    task automatic test_reset_midflight();
        clear_ops();
        n_ops   = 1;
        op_a[0] = 8'h12; op_b[0] = 8'h34; op_c[0] = 1'b0; op_v[0] = 1'b1;
        for (int k = 0; k <= D; k++) begin
            drive_slot(k);
            tick();
        end
        total++; if (sum !== 8'h46) begin bad++; $display("FAIL pre_reset_sum got=%h exp=46", sum); end
        clear_ops();
        n_ops = 2;
        for (int i = 0; i < n_ops; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
            op_c[i] = 1'($urandom);
            op_v[i] = 1'b1;
        end
        drive_slot(0);
        tick();
        drive_slot(1);
        tick();
        #3 rst_n = 1'b0;
        #1;
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL async_reset_sum got=%h exp=00", sum); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid got=%b exp=0", out_valid); end
        #1 rst_n = 1'b1;
        for (int k = 2; k <= D + 1; k++) begin
            drive_slot(k);
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL post_reset_out_valid slot=%0d got=%b exp=0", k, out_valid);
            end
        end
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL post_reset_align_err got=%b exp=1", align_err); end
        go_idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL post_reset_clr got=%b exp=0", align_err); end
    endtask

    task automatic test_idle();
        logic [10:0] exp_r;
        clear_ops();
        n_ops   = 1;
        op_a[0] = 8'($urandom);
        op_b[0] = 8'($urandom);
        op_c[0] = 1'($urandom);
        op_v[0] = 1'b1;
        exp_r   = model_res(op_a[0], op_b[0], op_c[0]);
        for (int k = 0; k <= D; k++) begin
            drive_slot(k);
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL idle_setup_out_valid got=%b exp=1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            go_idle();
            tick();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
            total++;
            if ({zero, ovf, cout, sum} !== exp_r) begin
                bad++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", c, {zero, ovf, cout, sum}, exp_r);
            end
            total++;
            if (align_err !== 1'b0) begin bad++; $display("FAIL idle_align_err cyc=%0d got=%b exp=0", c, align_err); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        clear_ops();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_misalign();
        test_reset_midflight();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
